// File: rtl/debug_pd_stat_pkg.sv
// debug_pd_stat_pkg: register map, counter IDs and overflow-status bit
// positions shared by the PD statistics back end.
package debug_pd_stat_pkg;

  // CIF register indices
  localparam logic [3:0] REG_F1    = 4'd0;
  localparam logic [3:0] REG_F2    = 4'd1;
  localparam logic [3:0] REG_CAP   = 4'd2;
  localparam logic [3:0] REG_TOT   = 4'd3;
  localparam logic [3:0] REG_B1_LO = 4'd4;
  localparam logic [3:0] REG_B1_HI = 4'd5;
  localparam logic [3:0] REG_B2_LO = 4'd6;
  localparam logic [3:0] REG_B2_HI = 4'd7;
  localparam logic [3:0] REG_OVF   = 4'd8;

  // Counter identifiers; the four event counters come first
  typedef enum logic [2:0] {
    CNT_F1  = 3'd0,
    CNT_F2  = 3'd1,
    CNT_CAP = 3'd2,
    CNT_TOT = 3'd3,
    CNT_B1  = 3'd4,
    CNT_B2  = 3'd5
  } cnt_id_e;

  // Bit positions inside the overflow status register
  localparam int OVF_BIT_F1  = 0;
  localparam int OVF_BIT_F2  = 1;
  localparam int OVF_BIT_CAP = 2;
  localparam int OVF_BIT_TOT = 3;
  localparam int OVF_BIT_B1  = 4;
  localparam int OVF_BIT_B2  = 5;

  // Register index whose clear-on-read clears the given counter
  function automatic logic [3:0] cnt_clr_addr(cnt_id_e id);
    case (id)
      CNT_F1:  return REG_F1;
      CNT_F2:  return REG_F2;
      CNT_CAP: return REG_CAP;
      CNT_TOT: return REG_TOT;
      CNT_B1:  return REG_B1_LO;
      CNT_B2:  return REG_B2_LO;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/debug_pd_stat_cnt.sv
// debug_pd_stat_cnt: one statistics counter with sticky overflow bit.
// DEBUG_PD_STAT_SATURATE_EN selects saturation at all-ones; otherwise the
// counter wraps. A clear in the same cycle as an increment leaves exactly
// that increment in the counter.
module debug_pd_stat_cnt
  import debug_pd_stat_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic [AMT_WIDTH-1:0] i_amount,
  input  logic                 i_clr,
  input  logic                 i_ovf_clr,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_overflow
);

  logic [WIDTH-1:0] r_value;
  logic             r_overflow;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_value_next;

  // Next value: clear first, then add; carry out marks overflow
  always_comb begin
    w_base  = i_clr ? '0 : r_value;
    w_sum   = {1'b0, w_base} + (WIDTH+1)'(i_amount);
    w_carry = i_inc & w_sum[WIDTH];
`ifdef DEBUG_PD_STAT_SATURATE_EN
    w_value_next = !i_inc ? w_base : (w_carry ? '1 : w_sum[WIDTH-1:0]);
`else
    w_value_next = i_inc ? w_sum[WIDTH-1:0] : w_base;
`endif
  end

  // Counter and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_value    <= w_value_next;
      r_overflow <= i_ovf_clr ? 1'b0 : (r_overflow | w_carry);
    end
  end

  assign o_value    = r_value;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/debug_pd_stat_counters.sv
// debug_pd_stat_counters: PD debug statistics counters with a one-cycle
// CIF read port, clear-on-read and tear-free 64-bit byte-counter reads.
// Build option: DEBUG_PD_STAT_SATURATE_EN (saturate instead of wrap).
module debug_pd_stat_counters
  import debug_pd_stat_pkg::*;
#(
  parameter int CNT_WIDTH         = 32,
  parameter int BYTE_CNT_WIDTH    = 48,
  parameter int PACKET_SIZE_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
  input  logic                         cif2dbg_c_debug_pd_stat_clr,
  input  logic                         cif_rd_req,
  input  logic [3:0]                   cif_rd_addr,
  input  logic                         cif_rd_clr,
  output logic                         cif_rd_ack,
  output logic [31:0]                  cif_rd_data
);

  logic                      w_rd_clr;
  logic [3:0]                w_evt_inc;
  logic [CNT_WIDTH-1:0]      w_evt_val [4];
  logic [3:0]                w_evt_ovf;
  logic [BYTE_CNT_WIDTH-1:0] w_b1_val;
  logic [BYTE_CNT_WIDTH-1:0] w_b2_val;
  logic                      w_b1_ovf;
  logic                      w_b2_ovf;
  logic [31:0]               w_b1_hi;
  logic [31:0]               w_b2_hi;
  logic [31:0]               w_ovf_status;
  logic [31:0]               w_rd_data;
  logic [31:0]               r_snap_b1;
  logic [31:0]               r_snap_b2;
  logic                      r_rd_ack;
  logic [31:0]               r_rd_data;

  assign w_rd_clr  = cif_rd_req & cif_rd_clr;
  assign w_evt_inc = {dbg2cif_e_debug_pd_total_pd_cnt_inc,
                      dbg2cif_e_debug_pd_capture_match_cnt_inc,
                      dbg2cif_e_debug_pd_field2_cnt_inc,
                      dbg2cif_e_debug_pd_field1_cnt_inc};

  // Event counters F1, F2, CAP, TOT (index = counter ID)
  for (genvar gi = 0; gi < 4; gi++) begin : g_evt
    debug_pd_stat_cnt #(.WIDTH(CNT_WIDTH), .AMT_WIDTH(1)) u_cnt_evt (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_evt_inc[gi]),
      .i_amount   (1'b1),
      .i_clr      (cif2dbg_c_debug_pd_stat_clr |
                   (w_rd_clr && (cif_rd_addr == cnt_clr_addr(cnt_id_e'(gi))))),
      .i_ovf_clr  (cif2dbg_c_debug_pd_stat_clr),
      .o_value    (w_evt_val[gi]),
      .o_overflow (w_evt_ovf[gi])
    );
  end

  debug_pd_stat_cnt #(.WIDTH(BYTE_CNT_WIDTH), .AMT_WIDTH(PACKET_SIZE_WIDTH)) u_cnt_b1 (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (dbg2cif_e_debug_pd_field1_byte_cnt_inc),
    .i_amount   (dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
    .i_clr      (cif2dbg_c_debug_pd_stat_clr |
                 (w_rd_clr && (cif_rd_addr == cnt_clr_addr(CNT_B1)))),
    .i_ovf_clr  (cif2dbg_c_debug_pd_stat_clr),
    .o_value    (w_b1_val),
    .o_overflow (w_b1_ovf)
  );

  debug_pd_stat_cnt #(.WIDTH(BYTE_CNT_WIDTH), .AMT_WIDTH(PACKET_SIZE_WIDTH)) u_cnt_b2 (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (dbg2cif_e_debug_pd_field2_byte_cnt_inc),
    .i_amount   (dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
    .i_clr      (cif2dbg_c_debug_pd_stat_clr |
                 (w_rd_clr && (cif_rd_addr == cnt_clr_addr(CNT_B2)))),
    .i_ovf_clr  (cif2dbg_c_debug_pd_stat_clr),
    .o_value    (w_b2_val),
    .o_overflow (w_b2_ovf)
  );

  assign w_b1_hi = 32'(w_b1_val >> 32);
  assign w_b2_hi = 32'(w_b2_val >> 32);

  // Overflow status word
  always_comb begin
    w_ovf_status              = '0;
    w_ovf_status[OVF_BIT_F1]  = w_evt_ovf[CNT_F1];
    w_ovf_status[OVF_BIT_F2]  = w_evt_ovf[CNT_F2];
    w_ovf_status[OVF_BIT_CAP] = w_evt_ovf[CNT_CAP];
    w_ovf_status[OVF_BIT_TOT] = w_evt_ovf[CNT_TOT];
    w_ovf_status[OVF_BIT_B1]  = w_b1_ovf;
    w_ovf_status[OVF_BIT_B2]  = w_b2_ovf;
  end

  // Read mux over pre-update values; high words come from the snapshots
  always_comb begin
    w_rd_data = '0;
    case (cif_rd_addr)
      REG_F1:    w_rd_data = 32'(w_evt_val[0]);
      REG_F2:    w_rd_data = 32'(w_evt_val[1]);
      REG_CAP:   w_rd_data = 32'(w_evt_val[2]);
      REG_TOT:   w_rd_data = 32'(w_evt_val[3]);
      REG_B1_LO: w_rd_data = w_b1_val[31:0];
      REG_B1_HI: w_rd_data = r_snap_b1;
      REG_B2_LO: w_rd_data = w_b2_val[31:0];
      REG_B2_HI: w_rd_data = r_snap_b2;
      REG_OVF:   w_rd_data = w_ovf_status;
      default:   w_rd_data = '0;
    endcase
  end

  // High-word snapshots taken when the low word is read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_b1 <= '0;
      r_snap_b2 <= '0;
    end else if (cif2dbg_c_debug_pd_stat_clr) begin
      r_snap_b1 <= '0;
      r_snap_b2 <= '0;
    end else if (cif_rd_req) begin
      if (cif_rd_addr == REG_B1_LO) r_snap_b1 <= w_b1_hi;
      if (cif_rd_addr == REG_B2_LO) r_snap_b2 <= w_b2_hi;
    end
  end

  // One-cycle read response; data is zero outside the ack cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack  <= cif_rd_req;
      r_rd_data <= cif_rd_req ? w_rd_data : '0;
    end
  end

  assign cif_rd_ack  = r_rd_ack;
  assign cif_rd_data = r_rd_data;

endmodule

// File: tb/tb_debug_pd_stat_counters.sv
// tb_debug_pd_stat_counters: directed test of the PD statistics counters,
// built with CNT_WIDTH=4. Expected values follow DEBUG_PD_STAT_SATURATE_EN.
module tb_debug_pd_stat_counters;

`ifdef DEBUG_PD_STAT_SATURATE_EN
  localparam logic [31:0] EXP_B1_LO_OVF = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_B1_HI_OVF = 32'h0000_FFFF;
  localparam logic [31:0] EXP_F1_16     = 32'h0000_000F;
  localparam logic [31:0] EXP_F1_17     = 32'h0000_000F;
`else
  localparam logic [31:0] EXP_B1_LO_OVF = 32'h0000_0100;
  localparam logic [31:0] EXP_B1_HI_OVF = 32'h0000_0000;
  localparam logic [31:0] EXP_F1_16     = 32'h0000_0000;
  localparam logic [31:0] EXP_F1_17     = 32'h0000_0001;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f1_inc = 1'b0, f2_inc = 1'b0, cap_inc = 1'b0, tot_inc = 1'b0;
  logic        b1_inc = 1'b0, b2_inc = 1'b0;
  logic [11:0] amount = '0;
  logic        stat_clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_clr = 1'b0;
  logic        rd_ack;
  logic [31:0] rd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debug_pd_stat_counters #(
    .CNT_WIDTH(4), .BYTE_CNT_WIDTH(48), .PACKET_SIZE_WIDTH(12)
  ) dut (
    .clk                                          (clk),
    .rst                                          (rst),
    .dbg2cif_e_debug_pd_field1_cnt_inc            (f1_inc),
    .dbg2cif_e_debug_pd_field2_cnt_inc            (f2_inc),
    .dbg2cif_e_debug_pd_capture_match_cnt_inc     (cap_inc),
    .dbg2cif_e_debug_pd_total_pd_cnt_inc          (tot_inc),
    .dbg2cif_e_debug_pd_field1_byte_cnt_inc       (b1_inc),
    .dbg2cif_e_debug_pd_field2_byte_cnt_inc       (b2_inc),
    .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount(amount),
    .cif2dbg_c_debug_pd_stat_clr                  (stat_clr),
    .cif_rd_req                                   (rd_req),
    .cif_rd_addr                                  (rd_addr),
    .cif_rd_clr                                   (rd_clr),
    .cif_rd_ack                                   (rd_ack),
    .cif_rd_data                                  (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v = {b2, b1, tot, cap, f2, f1}
  task automatic set_inc(input logic [5:0] v, input logic [11:0] amt);
    {b2_inc, b1_inc, tot_inc, cap_inc, f2_inc, f1_inc} = v;
    amount = amt;
  endtask

  task automatic strobe(input logic [5:0] v, input logic [11:0] amt, input int n);
    set_inc(v, amt);
    repeat (n) tick();
    set_inc(6'b0, 12'h0);
  endtask

  task automatic pulse_stat_clr(input logic [5:0] v);
    stat_clr = 1'b1;
    set_inc(v, 12'h0);
    tick();
    stat_clr = 1'b0;
    set_inc(6'b0, 12'h0);
  endtask

  // One read transaction, optionally with increments in the request cycle
  task automatic rd(input logic [3:0] a, input logic c, input logic [5:0] v,
                    input logic [11:0] amt, input logic [31:0] exp, input string tag);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_clr  = c;
    set_inc(v, amt);
    tick();
    rd_req = 1'b0;
    rd_clr = 1'b0;
    set_inc(6'b0, 12'h0);
    $display("[TB] %s: rd addr=%0d clr=%0b ack=%0b data=0x%08h", tag, a, c, rd_ack, rd_data);
    check({tag, "_ack"}, {31'b0, rd_ack}, 32'h1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, rd_ack}, 32'h0);
    check("rst_data", rd_data, 32'h0);
    rst = 1'b0;
    tick();
    for (int a = 0; a <= 8; a++) rd(4'(a), 1'b0, 6'b0, 12'h0, 32'h0, $sformatf("rst_rd%0d", a));

    // Byte accumulation and tear-free read
    strobe(6'b010000, 12'h800, 3);
    rd(4'd4, 1'b0, 6'b0, 12'h0, 32'h0000_1800, "b1_lo");
    rd(4'd5, 1'b0, 6'b0, 12'h0, 32'h0, "b1_hi");
    rd(4'd6, 1'b0, 6'b0, 12'h0, 32'h0, "b2_lo_idle");

    // Preloaded B1 near the top of its range
    force dut.u_cnt_b1.r_value = 48'hFFFF_FFFF_FF00;
    rd_req  = 1'b1;
    rd_addr = 4'd4;
    tick();
    rd_req = 1'b0;
    release dut.u_cnt_b1.r_value;
    $display("[TB] pre_lo: rd addr=4 clr=0 ack=%0b data=0x%08h", rd_ack, rd_data);
    check("pre_lo_ack", {31'b0, rd_ack}, 32'h1);
    check("pre_lo", rd_data, 32'hFFFF_FF00);
    strobe(6'b010000, 12'h200, 1);
    rd(4'd5, 1'b0, 6'b0, 12'h0, 32'h0000_FFFF, "pre_hi_snap");
    rd(4'd8, 1'b0, 6'b0, 12'h0, 32'h0000_0010, "ovf_b1");
    rd(4'd4, 1'b0, 6'b0, 12'h0, EXP_B1_LO_OVF, "b1_lo_ovf");
    rd(4'd5, 1'b0, 6'b0, 12'h0, EXP_B1_HI_OVF, "b1_hi_ovf");
    pulse_stat_clr(6'b0);
    rd(4'd8, 1'b0, 6'b0, 12'h0, 32'h0, "clr_ovf");
    rd(4'd4, 1'b0, 6'b0, 12'h0, 32'h0, "clr_b1_lo");
    rd(4'd5, 1'b0, 6'b0, 12'h0, 32'h0, "clr_b1_hi");

    // Clear-on-read with a same-cycle increment
    strobe(6'b001000, 12'h0, 5);
    rd(4'd3, 1'b1, 6'b001000, 12'h0, 32'h5, "tot_rdclr");
    rd(4'd3, 1'b0, 6'b0, 12'h0, 32'h1, "tot_after");

    // stat_clr with a same-cycle increment keeps the increment
    pulse_stat_clr(6'b000010);
    rd(4'd1, 1'b0, 6'b0, 12'h0, 32'h1, "f2_statclr_inc");
    rd(4'd3, 1'b0, 6'b0, 12'h0, 32'h0, "tot_statclr");

    // 15 strobes: at all-ones, no overflow yet; 16th overflows
    strobe(6'b000001, 12'h0, 15);
    rd(4'd0, 1'b0, 6'b0, 12'h0, 32'hF, "f1_15");
    rd(4'd8, 1'b0, 6'b0, 12'h0, 32'h0, "ovf_f1_15");
    strobe(6'b000001, 12'h0, 1);
    rd(4'd0, 1'b0, 6'b0, 12'h0, EXP_F1_16, "f1_16");
    rd(4'd8, 1'b0, 6'b0, 12'h0, 32'h1, "ovf_f1_16");

    // 17 strobes from zero
    pulse_stat_clr(6'b0);
    strobe(6'b000001, 12'h0, 17);
    rd(4'd0, 1'b0, 6'b0, 12'h0, EXP_F1_17, "f1_17");
    rd(4'd8, 1'b0, 6'b0, 12'h0, 32'h1, "ovf_f1_17");
    rd(4'd9, 1'b0, 6'b0, 12'h0, 32'h0, "addr9");
    rd(4'd15, 1'b0, 6'b0, 12'h0, 32'h0, "addr15");
    rd(4'd0, 1'b1, 6'b0, 12'h0, EXP_F1_17, "f1_rdclr");
    rd(4'd0, 1'b0, 6'b0, 12'h0, 32'h0, "f1_after_rdclr");
    rd(4'd8, 1'b0, 6'b0, 12'h0, 32'h1, "ovf_kept_rdclr");
    pulse_stat_clr(6'b0);
    for (int a = 0; a <= 8; a++) rd(4'(a), 1'b0, 6'b0, 12'h0, 32'h0, $sformatf("statclr_rd%0d", a));

    // All six strobes in one cycle
    strobe(6'b111111, 12'h005, 1);
    for (int a = 0; a < 4; a++) rd(4'(a), 1'b0, 6'b0, 12'h0, 32'h1, $sformatf("all6_evt%0d", a));
    rd(4'd4, 1'b0, 6'b0, 12'h0, 32'h5, "all6_b1");
    rd(4'd6, 1'b1, 6'b0, 12'h0, 32'h5, "all6_b2_rdclr");
    rd(4'd6, 1'b0, 6'b0, 12'h0, 32'h0, "b2_after_rdclr");
    rd(4'd4, 1'b0, 6'b0, 12'h0, 32'h5, "b1_untouched");

    // Back-to-back reads of F1=1, F2=2, CAP=3, TOT=4
    pulse_stat_clr(6'b0);
    strobe(6'b001111, 12'h0, 1);
    strobe(6'b001110, 12'h0, 1);
    strobe(6'b001100, 12'h0, 1);
    strobe(6'b001000, 12'h0, 1);
    rd_req = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 4'(a);
      tick();
      $display("[TB] b2b%0d: rd addr=%0d clr=0 ack=%0b data=0x%08h", a, a, rd_ack, rd_data);
      check($sformatf("b2b_ack%0d", a), {31'b0, rd_ack}, 32'h1);
      check($sformatf("b2b_data%0d", a), rd_data, 32'(a + 1));
    end
    rd_req = 1'b0;
    tick();
    check("b2b_ack_end", {31'b0, rd_ack}, 32'h0);
    check("b2b_data_end", rd_data, 32'h0);

    // Asynchronous reset during an acknowledged read
    rd_req  = 1'b1;
    rd_addr = 4'd3;
    tick();
    rd_req = 1'b0;
    check("arst_pre_ack", {31'b0, rd_ack}, 32'h1);
    check("arst_pre_data", rd_data, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ack", {31'b0, rd_ack}, 32'h0);
    check("arst_data", rd_data, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    rd(4'd3, 1'b0, 6'b0, 12'h0, 32'h0, "arst_tot");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_pd_stat_counters.md
# debug_pd_stat_counters

Statistics back end for the PD debug-capture stage. It consumes the per-PD increment strobes and the byte-count amount that the capture stage drives toward CIF, and accumulates them in event and byte counters. It serves 32-bit CIF register reads over a one-cycle request/acknowledge port, with optional clear-on-read and tear-free 64-bit byte-counter reads. It sits between the capture stage and the CIF register decoder, in the same clock domain as the PD pipeline.

## Interface
- CNT_WIDTH, 32: width of event counters (1..32).
- BYTE_CNT_WIDTH, 48: width of byte counters (33..64).
- PACKET_SIZE_WIDTH, 12: width of the byte increment amount.
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- dbg2cif_e_debug_pd_field1_cnt_inc  in  1  field1 match strobe.
- dbg2cif_e_debug_pd_field2_cnt_inc  in  1  field2 match strobe.
- dbg2cif_e_debug_pd_capture_match_cnt_inc  in  1  capture-trigger strobe.
- dbg2cif_e_debug_pd_total_pd_cnt_inc  in  1  total PD strobe.
- dbg2cif_e_debug_pd_field1_byte_cnt_inc  in  1  field1 byte strobe.
- dbg2cif_e_debug_pd_field2_byte_cnt_inc  in  1  field2 byte strobe.
- dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount  in  PACKET_SIZE_WIDTH  bytes to add on a byte strobe.
- cif2dbg_c_debug_pd_stat_clr  in  1  pulse; clears all counters and overflow bits.
- cif_rd_req  in  1  read request, single-cycle.
- cif_rd_addr  in  4  register index.
- cif_rd_clr  in  1  clear-on-read qualifier, sampled with cif_rd_req.
- cif_rd_ack  out  1  read acknowledge.
- cif_rd_data  out  32  read data, valid when cif_rd_ack=1, otherwise 0.

## Operation
- Counters: F1, F2, CAP, TOT (CNT_WIDTH); B1, B2 (BYTE_CNT_WIDTH).
- Each strobe adds 1, or adds the amount for B1/B2. All six may fire in the same cycle.
- Without saturation, counters wrap modulo 2^width. The counter's sticky overflow bit sets on the wrap.
- Address map:
  - 0 F1, 1 F2, 2 CAP, 3 TOT (zero-extended).
  - 4 B1[31:0], 5 B1 high word, 6 B2[31:0], 7 B2 high word.
  - 8 overflow status {26'b0, ovf_B2, ovf_B1, ovf_TOT, ovf_CAP, ovf_F2, ovf_F1}.
  - 9-15 read as 0.
- Tear-free byte read: a read of address 4 or 6 latches bits [BYTE_CNT_WIDTH-1:32] (zero-extended) into a per-counter high snapshot register. Reads of 5 or 7 return that snapshot and never the live value.
- Clear-on-read (cif_rd_clr=1):
  - Addresses 0-3 and 4/6 clear the addressed counter after its value is sampled.
  - Addresses 5/7 and 8 ignore cif_rd_clr.
- Same-cycle increment and clear (read-clear or stat_clr): the counter's next value equals that cycle's increment only. The event is never lost.
- stat_clr also zeroes the snapshot registers and all overflow bits. It has priority over a same-cycle read-clear, with identical result.

## Timing
- Reset: all counters, snapshots, overflow bits, cif_rd_ack and cif_rd_data are 0.
- Read latency is 1 cycle. cif_rd_ack rises the cycle after cif_rd_req, for exactly one cycle.
- cif_rd_data returns the value held at the request cycle, i.e. excluding that cycle's increments.
- Back-to-back requests every cycle are legal, with one ack per request.
- Counter update latency: an increment is visible to a read requested in the following cycle.
- Reset asserted mid-read drops the pending ack.

## Configuration
- DEBUG_PD_STAT_SATURATE_EN defined:
  - Counters stick at all-ones instead of wrapping.
  - The overflow bit sets on the first increment that would exceed all-ones.
  - Clears restore counting.
- Not defined: counters wrap, and the overflow bit sets on wrap.

## Structure
- Shared package debug_pd_stat_pkg holds:
  - the register-index localparams (0-8);
  - an enum for counter IDs;
  - the overflow-status bit positions.
- One sub-module, debug_pd_stat_cnt, instanced six times.
  - Parameterised by width.
  - Inputs: inc, amount, clr.
  - Outputs: value, overflow.
  - Contains the saturate/wrap logic under the macro.

## Test plan
- Reset check:
  - Stimulus: reset, then read addresses 0-8.
  - Response: every ack'd read returns 0x0.
- Byte accumulation and tear-free read:
  - Stimulus: 3 field1 byte strobes with amount 0x800, then read 4 followed by 5.
  - Response: 0x00001800, then 0x0.
  - Follow-up: preload B1 to 0xFFFF_FFFF_FF00, read 4, add 0x200, read 5. Response: 0xFFFFFF00, then the 0xFFFF snapshot, not the post-add value.
- Clear-on-read with a same-cycle increment:
  - Stimulus: TOT=5; read 3 with cif_rd_clr while a total strobe fires, then read 3 again.
  - Response: 5, then 1.
- Wrap (macro undefined):
  - Stimulus: CNT_WIDTH=4, 17 F1 strobes.
  - Response: F1 reads 1, address 8 reads 0x1.
- Saturation (DEBUG_PD_STAT_SATURATE_EN defined):
  - Stimulus: CNT_WIDTH=4, 17 F1 strobes.
  - Response: F1 reads 0xF, ovf_F1=1.
  - Follow-up: after stat_clr, all registers read 0.
- Back-to-back reads with asynchronous reset:
  - Stimulus: read requests on 4 consecutive cycles to addresses 0,1,2,3.
  - Response: 4 consecutive acks with matching data.
  - Follow-up: assert rst asynchronously between clock edges. cif_rd_ack drops to 0 immediately.
